// File: rtl/rvm_sort_ctrl.sv
// Reverse-vending sorter: debounced sensor word, classify, chute/reject flag,
// saturating BCD item count on a multiplexed 7-segment display.
module rvm_sort_ctrl #(
  parameter int N_TYPES         = 3,
  parameter int DEBOUNCE_CYCLES = 1000000,
  parameter int FLAG_CYCLES     = 50000000,
  parameter int DIGITS          = 4,
  parameter int REFRESH_DIV     = 100000
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [N_TYPES:0]   sensor,
  input  logic               count_clr,
  output logic [N_TYPES-1:0] chute,
  output logic               LED,
  output logic               busy,
  output logic [DIGITS-1:0]  anodes,
  output logic [6:0]         cathodes
);

  localparam int DW = $clog2(DEBOUNCE_CYCLES);
  localparam int FW = $clog2(FLAG_CYCLES + 1);
  localparam int RW = $clog2(REFRESH_DIV + 1);
  localparam int IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;

  localparam logic [DW-1:0] DB_MAX = DW'(DEBOUNCE_CYCLES - 1);
  localparam logic [FW-1:0] F_MAX  = FW'(FLAG_CYCLES - 1);
  localparam logic [RW-1:0] R_MAX  = RW'(REFRESH_DIV - 1);
  localparam logic [IW-1:0] I_MAX  = IW'(DIGITS - 1);

  typedef enum logic [2:0] {
    IDLE, DEBOUNCE, CLASSIFY, SORT, REJECT, WAIT_CLEAR
  } state_t;

  state_t               state;
  logic [N_TYPES:0]     s1, s;
  logic [DW-1:0]        db;
  logic                 db_done;
  logic [N_TYPES-1:0]   cls;
  logic                 one_hot;
  logic [FW-1:0]        fcnt;
  logic [4*DIGITS-1:0]  count, count_nxt;
  logic                 carry, all9;
  logic [RW-1:0]        div;
  logic [IW-1:0]        idx, idx_nxt;
  logic [3:0]           digit;

  // Counter clears on the edge a new word enters s, so it reads
  // "stable cycles minus one" for the word currently in s.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      s1 <= '0;
      s  <= '0;
      db <= '0;
    end else begin
      s1 <= sensor;
      s  <= s1;
      if (s1 != s)
        db <= '0;
      else if (db != DB_MAX)
        db <= db + 1'b1;
    end
  end

  assign db_done = (db == DB_MAX);
  assign one_hot = (|cls) && ((cls & (cls - 1'b1)) == '0);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
      cls   <= '0;
      fcnt  <= '0;
      chute <= '0;
      LED   <= 1'b0;
      busy  <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          if (s[0]) begin
            state <= DEBOUNCE;
            busy  <= 1'b1;
          end
        end
        DEBOUNCE: begin
          if (!s[0]) begin
            state <= IDLE;
            busy  <= 1'b0;
          end else if (db_done) begin
            state <= CLASSIFY;
            cls   <= s[N_TYPES:1];
          end
        end
        CLASSIFY: begin
          fcnt <= '0;
          if (one_hot) begin
            state <= SORT;
            chute <= cls;
          end else begin
            state <= REJECT;
            LED   <= 1'b1;
          end
        end
        SORT, REJECT: begin
          if (fcnt == F_MAX) begin
            state <= WAIT_CLEAR;
            chute <= '0;
            LED   <= 1'b0;
          end else begin
            fcnt <= fcnt + 1'b1;
          end
        end
        WAIT_CLEAR: begin
          if (!s[0] && db_done) begin
            state <= IDLE;
            busy  <= 1'b0;
          end
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

  always_comb begin
    count_nxt = count;
    carry     = 1'b1;
    all9      = 1'b1;
    for (int i = 0; i < DIGITS; i++)
      if (count[4*i +: 4] != 4'd9) all9 = 1'b0;
    if (state == CLASSIFY && one_hot && !all9) begin
      for (int i = 0; i < DIGITS; i++) begin
        if (carry) begin
          if (count[4*i +: 4] == 4'd9) begin
            count_nxt[4*i +: 4] = 4'd0;
          end else begin
            count_nxt[4*i +: 4] = count[4*i +: 4] + 4'd1;
            carry = 1'b0;
          end
        end
      end
    end else if (state == IDLE && count_clr) begin
      count_nxt = '0;
    end
  end

  always_comb begin
    idx_nxt = idx;
    if (div == R_MAX)
      idx_nxt = (idx == I_MAX) ? '0 : idx + 1'b1;
    digit = '0;
    for (int i = 0; i < DIGITS; i++)
      if (idx_nxt == IW'(i)) digit = count_nxt[4*i +: 4];
  end

  function automatic logic [6:0] glyph(input logic [3:0] d);
    case (d)
      4'd0:    glyph = 7'b1000000;
      4'd1:    glyph = 7'b1111001;
      4'd2:    glyph = 7'b0100100;
      4'd3:    glyph = 7'b0110000;
      4'd4:    glyph = 7'b0011001;
      4'd5:    glyph = 7'b0010010;
      4'd6:    glyph = 7'b0000010;
      4'd7:    glyph = 7'b1111000;
      4'd8:    glyph = 7'b0000000;
      4'd9:    glyph = 7'b0010000;
      default: glyph = 7'b1111111;
    endcase
  endfunction

  // Display registers load from next-state values so the lit digit
  // always matches the count and scan index held this cycle.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count    <= '0;
      div      <= '0;
      idx      <= '0;
      anodes   <= ~DIGITS'(1);
      cathodes <= 7'b1000000;
    end else begin
      count    <= count_nxt;
      div      <= (div == R_MAX) ? '0 : div + 1'b1;
      idx      <= idx_nxt;
      anodes   <= ~(DIGITS'(1) << idx_nxt);
      cathodes <= glyph(digit);
    end
  end

endmodule

// File: doc/rvm_sort_ctrl.md
RVM_SORT_CTRL -- requirements
Module: rvm_sort_ctrl

Interface
REQ-001 Parameter N_TYPES, 3, number of material classes/chutes; legal range 1..7.
REQ-002 Parameter DEBOUNCE_CYCLES, 1000000, consecutive stable cycles required before a sensor word is accepted; minimum 2.
REQ-003 Parameter FLAG_CYCLES, 50000000, cycles a chute flag or the reject LED stays high per item; minimum 1.
REQ-004 Parameter DIGITS, 4, number of 7-segment digits; legal range 1..8.
REQ-005 Parameter REFRESH_DIV, 100000, clock cycles each digit is driven during multiplexing; minimum 1.
REQ-006 clk  input  1  system clock; all state changes on its rising edge.
REQ-007 reset  input  1  asynchronous, active-high reset.
REQ-008 sensor  input  N_TYPES+1  bit0 = item present; bits N_TYPES:1 = one-hot material class; asynchronous to clk.
REQ-009 count_clr  input  1  synchronous clear of the accepted-item count, honoured only in IDLE.
REQ-010 chute  output  N_TYPES  per-class sort flag; one-hot or all zero.
REQ-011 LED  output  1  reject indicator.
REQ-012 busy  output  1  high in every FSM state except IDLE.
REQ-013 anodes  output  DIGITS  digit enables, active-low, exactly one low at a time.
REQ-014 cathodes  output  7  segments {g,f,e,d,c,b,a}, active-low.

Function
REQ-015 sensor SHALL pass through a 2-flop synchroniser; all logic uses the synchronised word S.
REQ-016 Debounce counter SHALL reset to 0 whenever S differs from its previous-cycle value and increment otherwise, saturating at DEBOUNCE_CYCLES-1.
REQ-017 FSM states SHALL be IDLE, DEBOUNCE, CLASSIFY, SORT, REJECT, WAIT_CLEAR.
REQ-018 IDLE -> DEBOUNCE when S[0]=1.
REQ-019 DEBOUNCE -> IDLE when S[0]=0; -> CLASSIFY when counter reaches DEBOUNCE_CYCLES-1 with S[0]=1, latching S into W on that edge.
REQ-020 CLASSIFY (exactly 1 cycle) -> SORT if W[N_TYPES:1] has exactly one bit set, else -> REJECT (zero or multiple bits).
REQ-021 SORT: chute[k-1]=1 for the set bit W[k], held exactly FLAG_CYCLES cycles, then -> WAIT_CLEAR; accepted count increments by 1 on SORT entry.
REQ-022 REJECT: LED=1 for exactly FLAG_CYCLES cycles, then -> WAIT_CLEAR; count unchanged.
REQ-023 SORT/REJECT SHALL run to completion regardless of sensor changes during them.
REQ-024 WAIT_CLEAR -> IDLE only after S[0]=0 has been debounced (DEBOUNCE_CYCLES stable cycles); prevents double counting of one item.
REQ-025 Latency: sensor change at input to first chute/LED cycle SHALL be DEBOUNCE_CYCLES+3 clock edges (2 sync, debounce, 1 CLASSIFY).
REQ-026 Count SHALL be held as DIGITS BCD digits, saturating at all-9s; increment at saturation leaves it unchanged.
REQ-027 count_clr=1 in IDLE SHALL zero the count next edge; ignored in any other state; increment takes priority as count_clr cannot coincide with SORT entry.
REQ-028 Display SHALL scan digit 0 (LSD, anodes[0]) upward, advancing every REFRESH_DIV cycles, wrapping from DIGITS-1 to 0.
REQ-029 cathodes SHALL show the standard decimal glyph of the selected digit (0 = 7'b1000000, 1 = 7'b1111001, 8 = 7'b0000000); no leading-zero blanking.
REQ-030 All outputs SHALL be registered.

Reset
REQ-031 reset=1 SHALL immediately force: FSM IDLE, count 0, debounce and flag counters 0, synchroniser 0, chute=0, LED=0, busy=0, scan index 0, anodes with only bit0 low, cathodes=7'b1000000.
REQ-032 reset asserted mid-SORT/REJECT SHALL drop chute/LED at once without incrementing or decrementing the count beyond the value already registered.
REQ-033 After reset release, operation SHALL resume from IDLE on the next rising edge.

Verification (N_TYPES=3, DEBOUNCE_CYCLES=4, FLAG_CYCLES=8, DIGITS=4, REFRESH_DIV=4)
REQ-034 sensor=4'b0011 held -> chute=3'b001 for 8 cycles starting 7 edges after change, count=0001, then busy stays 1 until sensor=0 debounced.
REQ-035 sensor=4'b1001 then 4'b0101 items -> chute=3'b100 then 3'b010, count=0002; sensor=4'b1111 -> LED=1 for 8 cycles, chute=0, count unchanged.
REQ-036 sensor bit0 pulses 1 for 3 cycles only -> FSM returns to IDLE, no flag, count unchanged.
REQ-037 preload 9999 via 9999 items (or force) then one more item -> chute pulses, count stays 9999; count_clr in IDLE -> 0000; count_clr during SORT ignored.
REQ-038 reset asserted 3 cycles into SORT -> chute=0 same cycle, count=0000, anodes=4'b1110, cathodes=7'b1000000; display with count 0042 cycles anodes 1110->1101->1011->0111 every 4 cycles showing 2,4,0,0.
